// File: rtl/axis_pulse_gen_pkg.sv
// Shared types, default widths and the sample-encoding helper for the
// trapezoidal pulse-train generator.
package axis_pulse_gen_pkg;

   localparam int DEF_DAC_DATA_WIDTH   = 14;
   localparam int DEF_AXIS_TDATA_WIDTH = 32;
   localparam int DEF_CNTR_WIDTH       = 32;
   localparam int DEF_PCNT_WIDTH       = 16;

   typedef enum logic [2:0] {
      IDLE,
      RISE,
      FLAT,
      FALL,
      GAP
   } state_e;

   // Two's-complement sample from an unsigned magnitude, 64 bits wide so any
   // tdata width up to 64 is a plain truncation of the result.
   function automatic logic [63:0] signed_sample(input logic [62:0] mag, input logic neg);
      return neg ? (64'd0 - {1'b0, mag}) : {1'b0, mag};
   endfunction

endpackage

// File: rtl/axis_pulse_gen_ramp.sv
// Saturating up/down step unit: holds the current magnitude and offers the
// next ramp value toward the limit (up) or toward zero (down).
module axis_pulse_gen_ramp #(
   parameter int MAG_WIDTH = 13
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic [MAG_WIDTH-1:0] load_mag,
   input  logic [MAG_WIDTH-1:0] step,
   input  logic [MAG_WIDTH-1:0] limit,
   input  logic                 dir,
   input  logic                 load,
   input  logic                 adv,
   output logic [MAG_WIDTH-1:0] mag,
   output logic [MAG_WIDTH-1:0] nxt_mag,
   output logic                 at_limit,
   output logic                 at_zero
);

   // One extra bit so mag+step can never wrap before the clamp.
   logic [MAG_WIDTH:0] sum;

   always_comb begin
      sum = {1'b0, mag} + {1'b0, step};
      if (dir)
         nxt_mag = (sum >= {1'b0, limit}) ? limit : sum[MAG_WIDTH-1:0];
      else
         nxt_mag = (mag <= step) ? '0 : (mag - step);
   end

   assign at_limit = (mag >= limit);
   assign at_zero  = (mag == '0);

   // NOTE: registers use non-blocking assignment so every flop samples the
   // pre-edge values regardless of block ordering.
   always_ff @(posedge aclk) begin
      if (!aresetn)
         mag <= '0;
      else if (load)
         mag <= load_mag;
      else if (adv)
         mag <= nxt_mag;
   end

endmodule

// File: rtl/axis_pulse_gen.sv
// Trapezoidal pulse-train generator with an AXI4-Stream master output;
// each accepted trigger emits a burst of rise/flat/fall/gap pulses.
module axis_pulse_gen
   import axis_pulse_gen_pkg::*;
#(
   parameter int DAC_DATA_WIDTH   = DEF_DAC_DATA_WIDTH,
   parameter int AXIS_TDATA_WIDTH = DEF_AXIS_TDATA_WIDTH,
   parameter int CNTR_WIDTH       = DEF_CNTR_WIDTH,
   parameter int PCNT_WIDTH       = DEF_PCNT_WIDTH
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic [DAC_DATA_WIDTH-2:0]   cfg_amp,
   input  logic                        cfg_neg,
   input  logic [DAC_DATA_WIDTH-2:0]   cfg_step,
   input  logic [CNTR_WIDTH-1:0]       cfg_flat,
   input  logic [CNTR_WIDTH-1:0]       cfg_gap,
   input  logic [PCNT_WIDTH-1:0]       cfg_count,
   input  logic                        trig,
   input  logic                        stop,
   output logic                        busy,
   output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                        m_axis_tvalid,
   output logic                        m_axis_tlast,
   input  logic                        m_axis_tready
);

   localparam int AW = DAC_DATA_WIDTH - 1;

   state_e                      state_q, state_d;
   logic [AW-1:0]               amp_q, step_q, step_eff;
   logic                        neg_q;
   logic [CNTR_WIDTH-1:0]       flat_q, gap_q;
   // Flat and gap never overlap, so one phase counter serves both.
   logic [CNTR_WIDTH-1:0]       cnt_q, cnt_d;
   logic [PCNT_WIDTH-1:0]       pulses_q, pulses_d;
   logic [AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
   logic                        tlast_q, tlast_d;

   logic          hs, load_cfg, emit, clear, pulse_done, finish;
   logic          ramp_dir, ramp_adv, ramp_clr, neg_sel;
   logic [AW-1:0] limit_sel, step_sel, mag, nxt_mag, sample_mag;
   logic          at_limit, at_zero;

   assign hs       = m_axis_tvalid & m_axis_tready;
   assign step_eff = (cfg_step == '0) ? AW'(1) : cfg_step;

   // While idle the ramp looks straight at cfg_* so the first sample is ready
   // on the edge that accepts the trigger.
   assign limit_sel = (state_q == IDLE) ? cfg_amp  : amp_q;
   assign step_sel  = (state_q == IDLE) ? step_eff : step_q;
   assign neg_sel   = (state_q == IDLE) ? cfg_neg  : neg_q;

   axis_pulse_gen_ramp #(
      .MAG_WIDTH(AW)
   ) u_ramp (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .load_mag ('0),
      .step     (step_sel),
      .limit    (limit_sel),
      .dir      (ramp_dir),
      .load     (ramp_clr),
      .adv      (ramp_adv),
      .mag      (mag),
      .nxt_mag  (nxt_mag),
      .at_limit (at_limit),
      .at_zero  (at_zero)
   );

   always_comb begin
      // NOTE: each signal written here gets a default first, so no path
      // through the case can leave it unassigned and infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      pulses_d   = pulses_q;
      ramp_dir   = 1'b1;
      ramp_adv   = 1'b0;
      ramp_clr   = 1'b0;
      load_cfg   = 1'b0;
      emit       = 1'b0;
      clear      = 1'b0;
      pulse_done = 1'b0;
      finish     = 1'b0;

      unique case (state_q)
         IDLE: if (trig && !stop && (cfg_count != '0)) begin
            load_cfg = 1'b1;
            state_d  = RISE;
            pulses_d = cfg_count;
            ramp_adv = 1'b1;
            emit     = 1'b1;
         end
         RISE: if (hs) begin
            emit = 1'b1;
            if (!at_limit) begin
               ramp_adv = 1'b1;
            end else if (flat_q != '0) begin
               state_d = FLAT;
               cnt_d   = CNTR_WIDTH'(1);
            end else begin
               state_d  = FALL;
               ramp_dir = 1'b0;
               ramp_adv = 1'b1;
            end
         end
         FLAT: if (hs) begin
            emit = 1'b1;
            if (cnt_q == flat_q) begin
               state_d  = FALL;
               ramp_dir = 1'b0;
               ramp_adv = 1'b1;
            end else begin
               cnt_d = cnt_q + CNTR_WIDTH'(1);
            end
         end
         FALL: if (hs) begin
            emit = 1'b1;
            if (!at_zero) begin
               ramp_dir = 1'b0;
               ramp_adv = 1'b1;
            end else if (gap_q != '0) begin
               state_d = GAP;
               cnt_d   = CNTR_WIDTH'(1);
            end else begin
               pulse_done = 1'b1;
            end
         end
         GAP: if (hs) begin
            emit = 1'b1;
            if (cnt_q == gap_q) pulse_done = 1'b1;
            else                cnt_d = cnt_q + CNTR_WIDTH'(1);
         end
         default: state_d = IDLE;
      endcase

      if (pulse_done) begin
         if (pulses_q == PCNT_WIDTH'(1)) begin
            finish = 1'b1;
         end else begin
            state_d  = RISE;
            pulses_d = pulses_q - PCNT_WIDTH'(1);
            ramp_adv = 1'b1;
         end
      end

      // Abort drops tvalid immediately, even mid-sample.
      if (finish || (stop && (state_q != IDLE))) begin
         state_d  = IDLE;
         cnt_d    = '0;
         pulses_d = '0;
         ramp_adv = 1'b0;
         ramp_clr = 1'b1;
         emit     = 1'b0;
         clear    = 1'b1;
      end
   end

   // Kept apart from the control block so nxt_mag never feeds back into it.
   always_comb begin
      sample_mag = ramp_adv ? nxt_mag : mag;
      tdata_d    = tdata_q;
      tlast_d    = tlast_q;
      if (clear) begin
         tdata_d = '0;
         tlast_d = 1'b0;
      end else if (emit) begin
         tdata_d = AXIS_TDATA_WIDTH'(signed_sample(63'(sample_mag), neg_sel));
         tlast_d = (pulses_d == PCNT_WIDTH'(1)) &&
                   (((state_d == FALL) && (sample_mag == '0) && (gap_q == '0)) ||
                    ((state_d == GAP) && (cnt_d == gap_q)));
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         pulses_q <= '0;
         tdata_q  <= '0;
         tlast_q  <= 1'b0;
         amp_q    <= '0;
         step_q   <= '0;
         neg_q    <= 1'b0;
         flat_q   <= '0;
         gap_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pulses_q <= pulses_d;
         tdata_q  <= tdata_d;
         tlast_q  <= tlast_d;
         if (load_cfg) begin
            amp_q  <= cfg_amp;
            step_q <= step_eff;
            neg_q  <= cfg_neg;
            flat_q <= cfg_flat;
            gap_q  <= cfg_gap;
         end
      end
   end

   assign busy          = (state_q != IDLE);
   assign m_axis_tvalid = (state_q != IDLE);
   assign m_axis_tdata  = tdata_q;
   assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_axis_pulse_gen.sv
// Directed self-checking bench for axis_pulse_gen: bursts, polarity, edge
// configs, backpressure, abort, ignored triggers and mid-burst reset.
module tb_axis_pulse_gen;

   localparam int DW = 14;
   localparam int TW = 32;
   localparam int CW = 32;
   localparam int PW = 16;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic [DW-2:0] cfg_amp, cfg_step;
   logic          cfg_neg;
   logic [CW-1:0] cfg_flat, cfg_gap;
   logic [PW-1:0] cfg_count;
   logic          trig, stop, busy;
   logic [TW-1:0] m_axis_tdata;
   logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [TW-1:0] exp_q[$];

   always #5 aclk = ~aclk;

   axis_pulse_gen dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .cfg_amp       (cfg_amp),
      .cfg_neg       (cfg_neg),
      .cfg_step      (cfg_step),
      .cfg_flat      (cfg_flat),
      .cfg_gap       (cfg_gap),
      .cfg_count     (cfg_count),
      .trig          (trig),
      .stop          (stop),
      .busy          (busy),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, " tvalid"}, 32'(m_axis_tvalid), 32'd0);
      check({tag, " busy"},   32'(busy),          32'd0);
      check({tag, " tlast"},  32'(m_axis_tlast),  32'd0);
      check({tag, " tdata"},  m_axis_tdata,       32'd0);
   endtask

   task automatic set_cfg(input logic [12:0] amp, input logic [12:0] step,
                          input logic [31:0] flat, input logic [31:0] gap,
                          input logic [15:0] count, input logic neg);
      cfg_amp   = amp;
      cfg_step  = step;
      cfg_flat  = flat;
      cfg_gap   = gap;
      cfg_count = count;
      cfg_neg   = neg;
   endtask

   task automatic load_basic();
      exp_q = '{32'd40, 32'd80, 32'd100, 32'd100, 32'd100, 32'd60, 32'd20, 32'd0, 32'd0};
   endtask

   // Pulses trig for one cycle, then consumes exp_q with tready asserted pct%
   // of the time. mid_trig >= 0 re-asserts trig (and scrambles cfg) at that
   // loop cycle; end_trig leaves trig high from the final handshake onward.
   task automatic run_burst(input string tag, input int pct, input int mid_trig, input bit end_trig);
      int            idx;
      int            budget;
      bit            hold;
      logic [TW-1:0] h_data;
      logic          h_last;
      idx    = 0;
      hold   = 1'b0;
      h_data = '0;
      h_last = 1'b0;
      budget = (pct >= 100) ? exp_q.size() + 20 : exp_q.size() * 20 + 50;
      trig = 1'b1;
      tick();
      trig = 1'b0;
      for (int cyc = 0; cyc < budget && idx < exp_q.size(); cyc++) begin
         m_axis_tready = (pct >= 100) || (int'($urandom_range(0, 99)) < pct);
         trig = (cyc == mid_trig);
         if (cyc == mid_trig) begin
            cfg_amp   = 13'd7;
            cfg_count = 16'd5;
         end
         if (m_axis_tvalid !== 1'b1) begin
            check({tag, " tvalid"}, 32'(m_axis_tvalid), 32'd1);
            break;
         end
         if (hold) begin
            check({tag, " stable tdata"}, m_axis_tdata, h_data);
            check({tag, " stable tlast"}, 32'(m_axis_tlast), 32'(h_last));
         end
         if (m_axis_tready) begin
            check({tag, " tdata"}, m_axis_tdata, exp_q[idx]);
            check({tag, " tlast"}, 32'(m_axis_tlast), 32'(idx == exp_q.size() - 1));
            if (end_trig && (idx == exp_q.size() - 1)) trig = 1'b1;
            idx++;
            hold = 1'b0;
         end else begin
            hold   = 1'b1;
            h_data = m_axis_tdata;
            h_last = m_axis_tlast;
         end
         tick();
      end
      m_axis_tready = 1'b1;
      check({tag, " sample count"}, 32'(idx), 32'(exp_q.size()));
      if (!end_trig) begin
         trig = 1'b0;
         check_idle({tag, " end"});
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      aresetn       = 1'b0;
      trig          = 1'b0;
      stop          = 1'b0;
      m_axis_tready = 1'b1;
      set_cfg(13'd100, 13'd40, 32'd2, 32'd1, 16'd1, 1'b0);
      repeat (3) tick();
      check_idle("reset");
      aresetn = 1'b1;
      tick();

      // Basic positive burst.
      load_basic();
      run_burst("basic", 100, -1, 1'b0);

      // Same burst, negative polarity.
      set_cfg(13'd100, 13'd40, 32'd2, 32'd1, 16'd1, 1'b1);
      exp_q = '{32'hFFFF_FFD8, 32'hFFFF_FFB0, 32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'hFFFF_FF9C,
                32'hFFFF_FFC4, 32'hFFFF_FFEC, 32'h0000_0000, 32'h0000_0000};
      run_burst("neg", 100, -1, 1'b0);

      // Backpressure, with a trigger and cfg change while busy.
      set_cfg(13'd100, 13'd40, 32'd2, 32'd1, 16'd1, 1'b0);
      load_basic();
      run_burst("bp", 30, 3, 1'b0);
      repeat (3) tick();
      check_idle("bp after");

      // Trigger held across the final handshake starts only one cycle later.
      set_cfg(13'd100, 13'd40, 32'd2, 32'd1, 16'd1, 1'b0);
      load_basic();
      run_burst("endtrig", 100, -1, 1'b1);
      check_idle("endtrig gap");
      tick();
      trig = 1'b0;
      check("endtrig restart tvalid", 32'(m_axis_tvalid), 32'd1);
      check("endtrig restart tdata", m_axis_tdata, 32'd40);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check_idle("endtrig stop");

      // Full-scale amplitude, unit step, no flat, no gap, two pulses.
      set_cfg(13'd8191, 13'd0, 32'd0, 32'd0, 16'd2, 1'b0);
      exp_q.delete();
      for (int p = 0; p < 2; p++) begin
         for (int k = 1; k <= 8191; k++) exp_q.push_back(32'(k));
         for (int k = 8190; k >= 0; k--) exp_q.push_back(32'(k));
      end
      run_burst("edge", 100, -1, 1'b0);

      // Abort during the flat top.
      set_cfg(13'd100, 13'd40, 32'd10, 32'd1, 16'd1, 1'b0);
      trig = 1'b1;
      tick();
      trig = 1'b0;
      repeat (4) tick();
      check("abort pre tdata", m_axis_tdata, 32'd100);
      check("abort pre busy", 32'(busy), 32'd1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check_idle("abort");
      repeat (2) tick();
      check_idle("abort stays");

      // Zero pulse count never starts.
      set_cfg(13'd100, 13'd40, 32'd2, 32'd1, 16'd0, 1'b0);
      trig = 1'b1;
      repeat (2) tick();
      trig = 1'b0;
      check_idle("count0");

      // Stop wins over trig in the same idle cycle.
      set_cfg(13'd100, 13'd40, 32'd2, 32'd1, 16'd1, 1'b0);
      stop = 1'b1;
      trig = 1'b1;
      tick();
      stop = 1'b0;
      trig = 1'b0;
      check_idle("stop+trig");
      tick();
      check_idle("stop+trig after");

      // Reset during the rise, then a clean restart.
      trig = 1'b1;
      tick();
      trig = 1'b0;
      tick();
      check("midreset pre tdata", m_axis_tdata, 32'd80);
      aresetn = 1'b0;
      tick();
      aresetn = 1'b1;
      check_idle("midreset");
      load_basic();
      run_burst("restart", 100, -1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/axis_pulse_gen.md
Name: axis_pulse_gen

Overview:
Trapezoidal pulse-train generator, the stage directly upstream of the DAC output stage. Each accepted trigger starts a burst of N pulses: rise ramp, flat top, fall ramp, then zero gap. Samples go out on an AXI4-Stream master as signed two's-complement in the low DAC_DATA_WIDTH bits. Backpressure is honoured, although the downstream DAC stage holds tready high.

Parameters:
DAC_DATA_WIDTH, 14, sample width; the amplitude is DAC_DATA_WIDTH-1 bits unsigned.
AXIS_TDATA_WIDTH, 32, master tdata width; must be >= DAC_DATA_WIDTH.
CNTR_WIDTH, 32, width of the flat and gap duration counters.
PCNT_WIDTH, 16, width of the pulse-count counter.

Ports:
aclk  in  1  clock; the block's only clock.
aresetn  in  1  synchronous, active-low reset.
cfg_amp  in  DAC_DATA_WIDTH-1  pulse magnitude, unsigned.
cfg_neg  in  1  1 = negative-going pulses.
cfg_step  in  DAC_DATA_WIDTH-1  ramp increment per sample; 0 is treated as 1.
cfg_flat  in  CNTR_WIDTH  flat-top samples after the peak sample.
cfg_gap  in  CNTR_WIDTH  zero samples after the fall ramp.
cfg_count  in  PCNT_WIDTH  pulses per burst.
trig  in  1  start request, level-sampled.
stop  in  1  abort request.
busy  out  1  high while a burst is in progress.
m_axis_tdata  out  AXIS_TDATA_WIDTH  sign-extended sample.
m_axis_tvalid  out  1  sample valid.
m_axis_tlast  out  1  marks the final sample of the burst.
m_axis_tready  in  1  downstream ready.

Behaviour:
- Reset (aresetn=0 at a rising edge of aclk):
  - state=IDLE; busy, m_axis_tvalid and m_axis_tlast = 0; m_axis_tdata = 0; all counters cleared.
  - Reset mid-burst aborts at once; no further samples are emitted.
- States: IDLE, RISE, FLAT, FALL, GAP.
- Burst start:
  - In IDLE, trig=1 with cfg_count!=0 latches every cfg_* input into shadow registers.
  - Next cycle: state=RISE, busy=1, tvalid=1 holding the first sample.
  - trig is ignored outside IDLE and when cfg_count=0.
  - cfg_* changes during a burst have no effect.
- Sample sequence for one pulse, magnitude m, with A=amp, S=max(step,1):
  - RISE: m_k=min(k*S, A) for k=1.., ending with the sample equal to A.
  - FLAT: cfg_flat samples of A. When cfg_flat=0, FALL follows the peak directly.
  - FALL: max(A-k*S, 0) for k=1.., ending with the sample equal to 0.
  - GAP: cfg_gap samples of 0, then the next pulse's RISE, or IDLE when the pulse count is exhausted.
  - A=0: RISE emits a single 0, FALL emits a single 0.
- Arithmetic:
  - Ramps saturate; compute on DAC_DATA_WIDTH bits so that A+S cannot wrap.
  - tdata = sign-extend(cfg_neg ? -m : m) to AXIS_TDATA_WIDTH.
  - The range is ±(2^(DAC_DATA_WIDTH-1)-1); the most negative code is never produced.
- Handshake:
  - A sample advances only on tvalid&tready.
  - tdata, tvalid and tlast stay stable while tready=0.
  - tvalid stays continuously high from burst start to the final handshake; there are no bubbles when tready=1.
  - The output is registered, and the next sample is available the cycle after a handshake, so throughput is 1 sample/clock.
- Burst end:
  - tlast=1 only on the last sample of the last pulse: the final gap zero, or the fall's 0 when cfg_gap=0.
  - After that handshake: tvalid=0, tlast=0, busy=0, state=IDLE.
  - A trig in that same cycle is not accepted; it is sampled from the next cycle.
- stop=1 in any non-IDLE state: next cycle state=IDLE, tvalid=0, busy=0, tdata=0, with no tlast.
  - This deliberately breaks AXIS stability; the DAC stage outputs midscale when tvalid=0.
  - stop and trig in the same IDLE cycle: stop wins and no burst starts.
- Counter edges: cfg_flat and cfg_gap up to 2^CNTR_WIDTH-1 are valid; cfg_count=2^PCNT_WIDTH-1 is valid.

Decomposition:
- Package axis_pulse_gen_pkg holds:
  - state enum (IDLE, RISE, FLAT, FALL, GAP);
  - default width constants;
  - a function for sign-extension/negation of the magnitude.
- One sub-module, axis_pulse_gen_ramp: saturating up/down step unit, combinational plus a magnitude register.
  - Inputs: mag, step, limit, dir, load, adv.
  - Outputs: mag, at_limit.
- The FSM, counters and AXIS register stay in the top.

Test Plan:
- Basic burst: A=100, S=40, flat=2, gap=1, count=1, neg=0, tready=1 -> tdata 40,80,100,100,100,60,20,0,0 on consecutive cycles starting the cycle after trig; tlast only on the 9th; busy falls after it.
- Negative polarity: same config with neg=1 -> 0xFFFFFFD8, 0xFFFFFFB0, 0xFFFFFF9C ×3, 0xFFFFFFC4, 0xFFFFFFEC, 0, 0.
- Edge configs: count=2, flat=0, gap=0, A=8191, S=0 -> each pulse is 8191 rise samples ending at 8191 and 8191 fall samples ending at 0; there is no tlast after pulse 1 and tlast on the final 0.
- Backpressure: random tready at 30% with the basic config -> the accepted sequence is identical to the first scenario; tdata/tvalid/tlast are stable while tready=0.
- Abort and ignored trigger:
  - stop mid-FLAT -> tvalid=0 and busy=0 next cycle, with no tlast.
  - trig while busy -> ignored.
  - trig with count=0 -> no output.
- Reset mid-RISE (aresetn=0 for 1 cycle) -> all outputs 0 after that edge; a new trig restarts from the first sample (40).
